// File: rtl/vreg_wport_arbiter_if.sv
// vreg_wport_arbiter_if: write-port, loader, reservation and hazard signals of the vector regfile arbiter
interface vreg_wport_arbiter_if #(
    parameter int NREGS = 10,
    parameter int AW    = 4,
    parameter int LANES = 6,
    parameter int EW    = 8
);
    logic                wb_we;
    logic [AW-1:0]       wb_addr;
    logic [LANES*EW-1:0] wb_data;
    logic                ld_valid;
    logic                ld_ready;
    logic [AW-1:0]       ld_addr;
    logic [LANES*EW-1:0] ld_data;
    logic                rsv_valid;
    logic [AW-1:0]       rsv_addr;
    logic [AW-1:0]       rd_addr1;
    logic [AW-1:0]       rd_addr2;
    logic                rd_busy1;
    logic                rd_busy2;
    logic                wb_stall;
    logic                rf_we;
    logic [AW-1:0]       rf_waddr;
    logic [LANES*EW-1:0] rf_wdata;
    logic [NREGS-1:0]    busy_map;
    logic                err_wb_drop;
    modport slave (
        input  wb_we, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
               rsv_valid, rsv_addr, rd_addr1, rd_addr2,
        output ld_ready, rd_busy1, rd_busy2, wb_stall,
               rf_we, rf_waddr, rf_wdata, busy_map, err_wb_drop
    );
    modport master (
        output wb_we, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
               rsv_valid, rsv_addr, rd_addr1, rd_addr2,
        input  ld_ready, rd_busy1, rd_busy2, wb_stall,
               rf_we, rf_waddr, rf_wdata, busy_map, err_wb_drop
    );
endinterface

// File: rtl/vreg_wport_arbiter.sv
// vreg_wport_arbiter: shares the regfile write port between writeback and loader, tracks pending loads
module vreg_wport_arbiter #(
    parameter int NREGS    = 10,
    parameter int AW       = 4,
    parameter int LANES    = 6,
    parameter int EW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    vreg_wport_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {NORMAL, DRAIN, FORCE} state_t;
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
    localparam logic [3:0]    MW   = 4'(MAX_WAIT);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_wait_cnt, w_wait_nxt;
    logic                w_wb_grant, w_ld_ready, w_wb_drop;
    logic                w_wb_in, w_ld_in, w_rsv_in;
    logic                r_rf_we, r_ld_commit, r_err;
    logic [AW-1:0]       r_rf_waddr;
    logic [LANES*EW-1:0] r_rf_wdata;
    logic [NREGS-1:0]    r_busy, w_clr, w_set;

    assign w_wb_in  = bus.wb_addr <= LAST;
    assign w_ld_in  = bus.ld_addr <= LAST;
    assign w_rsv_in = bus.rsv_addr <= LAST;

    always_comb begin
        w_wb_grant  = bus.wb_we && r_state != FORCE;
        w_ld_ready  = bus.ld_valid && !w_wb_grant;
        w_wb_drop   = bus.wb_we && r_state == FORCE;
        w_wait_nxt  = (r_state == NORMAL && bus.ld_valid && !w_ld_ready) ? r_wait_cnt + 4'd1 : 4'd0;
        w_state_nxt = r_state == NORMAL ? (w_wait_nxt == MW ? DRAIN : NORMAL) :
                      r_state == DRAIN  ? (w_ld_ready ? NORMAL : FORCE) : NORMAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= NORMAL;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // A new reservation wins over the clear of the same register's completing load
    assign w_clr = r_ld_commit ? NREGS'(1) << r_rf_waddr : '0;
    assign w_set = (bus.rsv_valid && w_rsv_in) ? NREGS'(1) << bus.rsv_addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we     <= 1'b0;
            r_ld_commit <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_err       <= 1'b0;
            r_busy      <= '0;
        end else begin
            r_rf_we     <= (w_wb_grant && w_wb_in) || (w_ld_ready && w_ld_in);
            r_ld_commit <= w_ld_ready && w_ld_in;
            r_rf_waddr  <= w_ld_ready ? bus.ld_addr : w_wb_grant ? bus.wb_addr : '0;
            r_rf_wdata  <= w_ld_ready ? bus.ld_data : w_wb_grant ? bus.wb_data : '0;
            r_err       <= w_wb_drop;
            r_busy      <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign bus.ld_ready    = w_ld_ready;
    assign bus.wb_stall    = r_state != NORMAL;
    assign bus.rf_we       = r_rf_we;
    assign bus.rf_waddr    = r_rf_waddr;
    assign bus.rf_wdata    = r_rf_wdata;
    assign bus.err_wb_drop = r_err;
    assign bus.busy_map    = r_busy;
    assign bus.rd_busy1    = bus.rd_addr1 <= LAST && r_busy[bus.rd_addr1];
    assign bus.rd_busy2    = bus.rd_addr2 <= LAST && r_busy[bus.rd_addr2];
endmodule

// File: doc/vreg_wport_arbiter.md
Name: vreg_wport_arbiter

Overview:
- Owns the single write port (WE3/A3/WD3) of the 10 x 6-lane x 8-bit vector register file.
- Shares the port between the pipeline writeback stage (priority) and the memory loader (valid/ready), with a starvation guard that briefly stalls the pipeline.
- Keeps a busy scoreboard of registers with outstanding loads so decode can detect read hazards on A1/A2.

Parameters:
- NREGS, 10: number of vector registers.
- AW, 4: register index width.
- LANES, 6: elements per vector.
- EW, 8: element width in bits.
- MAX_WAIT, 4: consecutive blocked loader cycles before a forced grant (legal range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wb_we  in  1  pipeline writeback write enable
- wb_addr  in  AW  writeback destination register
- wb_data  in  LANES*EW  writeback vector
- ld_valid  in  1  loader has a write pending
- ld_ready  out  1  loader write accepted this cycle (combinational)
- ld_addr  in  AW  loader destination register
- ld_data  in  LANES*EW  loader vector
- rsv_valid  in  1  loader launches a load; reserve the register
- rsv_addr  in  AW  register to reserve
- rd_addr1  in  AW  decode read index 1
- rd_addr2  in  AW  decode read index 2
- rd_busy1  out  1  rd_addr1 has a pending load (combinational)
- rd_busy2  out  1  rd_addr2 has a pending load (combinational)
- wb_stall  out  1  pipeline must hold writeback (registered state decode)
- rf_we  out  1  to regfile WE3 (registered)
- rf_waddr  out  AW  to regfile A3 (registered)
- rf_wdata  out  LANES*EW  to regfile WD3 (registered)
- busy_map  out  NREGS  scoreboard bits, bit i = register i
- err_wb_drop  out  1  one-cycle pulse: writeback discarded in FORCE (registered)

Behaviour:
- Reset: all outputs and registered state are 0; state = NORMAL; wait_cnt = 0; busy_map = 0.
- State NORMAL (wb_stall = 0):
  - wb_we = 1: grant writeback, so ld_ready = 0. A loader that is waiting (ld_valid = 1) increments wait_cnt.
  - wb_we = 0: ld_ready = ld_valid.
- When wait_cnt reaches MAX_WAIT: NORMAL -> DRAIN.
- State DRAIN (wb_stall = 1):
  - The in-flight wb_we is still honoured and has priority.
  - Next state is FORCE. If the loader was granted in DRAIN (wb_we = 0), next state is NORMAL instead.
- State FORCE (wb_stall = 1):
  - ld_ready = ld_valid; the loader is granted unconditionally.
  - A wb_we asserted here is dropped and err_wb_drop pulses next cycle.
  - Next state is NORMAL.
- wait_cnt clears on any loader grant, and when ld_valid = 0.
- Write latency: the grant in cycle n drives rf_we/rf_waddr/rf_wdata in cycle n+1. The regfile updates at the end of n+1, and a read in n+2 returns the new data.
- Out-of-range address (>= NREGS): the request is still granted/handshaken, but rf_we stays 0 for it and the scoreboard is unaffected.
- Scoreboard set: rsv_valid sets busy_map[rsv_addr].
- Scoreboard clear: clears on the edge where the loader write to that address is presented on rf_we (cycle n+1). Busy is therefore visible through n+1.
- Scoreboard conflict: set and clear on the same register in the same cycle leaves the bit set (new reservation wins).
- Re-reserve of a busy register leaves it busy. Only one outstanding load per register is supported.
- A writeback to a busy register is permitted and does not change busy_map.
- Read hazard: rd_busyX = busy_map[rd_addrX] for an in-range address, otherwise 0.
- rst asserted mid-DRAIN/FORCE: the next cycle is NORMAL with all outputs 0. A pending ld_valid restarts arbitration from wait_cnt = 0.

Test Plan:
- Reset, then wb_we = 1, wb_addr = 3, wb_data = all 8'hAA -> next cycle rf_we = 1, rf_waddr = 3, rf_wdata = all 8'hAA; ld_ready = 0 throughout.
- ld_valid = 1, addr 5, with wb_we = 0 -> ld_ready = 1 same cycle; rf_we = 1, rf_waddr = 5 next cycle.
- ld_valid = 1 held with wb_we = 1 every cycle, MAX_WAIT = 4 -> DRAIN after 4 blocked cycles (wb_stall = 1, writeback still written). FORCE next cycle: ld_ready = 1 and the loader is written. Then NORMAL with wb_stall = 0.
- wb_we = 1 during FORCE, addr 2 -> rf_we carries the loader write only; err_wb_drop = 1 for exactly one cycle.
- rsv_valid, addr 7 -> busy_map[7] = 1 and rd_busy1 = 1 for rd_addr1 = 7. Loader write to 7 clears the bit on the edge ending the rf_we cycle. Reserve of 7 in that same commit cycle keeps the bit at 1.
- Loader or writeback to addr 12; rd_addr2 = 12 -> handshake completes, rf_we = 0, busy_map unchanged, rd_busy2 = 0.
